// File: rtl/ex_stage_mdu_pkg.sv
// ex_stage_mdu_pkg: ALU/MDU opcode encodings, default MDU latencies and the ALU function.
package ex_stage_mdu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LUI, ALU_XOR, ALU_NOR
  } alu_op_e;
  typedef enum logic [3:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO
  } md_op_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      ALU_LUI: return {b[15:0], 16'b0};
      ALU_XOR: return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction
  function automatic logic is_md(input logic [3:0] op);
    return op != MD_NONE && op <= MD_MTLO;
  endfunction
endpackage

// File: rtl/ex_stage_mdu_core.sv
// mdu_core: multi-cycle mult/div unit; results wait in pending regs until the countdown commits them to HI/LO.
module mdu_core
  import ex_stage_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  logic [CW-1:0] r_cnt;
  logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic signed [63:0] w_sa, w_sb, w_prod_s;
  logic signed [31:0] w_quot_s, w_rem_s;
  logic [63:0] w_prod_u, w_res;
  logic w_div0, w_start;
  assign o_busy = r_cnt != '0;
  assign o_hi = r_hi;
  assign o_lo = r_lo;
  always_comb begin
    w_sa = {{32{i_a[31]}}, i_a};
    w_sb = {{32{i_b[31]}}, i_b};
    w_prod_s = w_sa * w_sb;
    w_prod_u = {32'b0, i_a} * {32'b0, i_b};
    w_div0 = i_b == '0;
    w_quot_s = $signed(i_a) / $signed(i_b);
    w_rem_s = $signed(i_a) % $signed(i_b);
    w_res = i_op == MD_MULT  ? w_prod_s :
            i_op == MD_MULTU ? w_prod_u :
            w_div0           ? {i_a, 32'hFFFF_FFFF} :
            i_op == MD_DIV   ? {w_rem_s, w_quot_s} : {i_a % i_b, i_a / i_b};
    w_start = !o_busy && i_op != MD_NONE && i_op <= MD_DIVU;
  end
  // commit at count==1 and mthi/mtlo (only accepted when idle) never coincide
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else begin
      if (r_cnt == CW'(1)) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      if (o_busy) r_cnt <= r_cnt - 1'b1;
      else if (w_start) begin
        {r_pend_hi, r_pend_lo} <= w_res;
        r_cnt <= i_op <= MD_MULTU ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end else if (i_op == MD_MTHI) r_hi <= i_a;
      else if (i_op == MD_MTLO) r_lo <= i_a;
    end
  end
endmodule

// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: EX stage with ALU, destination select and EX/MEM latch; MDU ops stall via BusyE while the MDU works.
module ex_stage_mdu
  import ex_stage_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic [2:0]  ALUCtrlE,
  input  logic        ALUSrcE,
  input  logic        RegDstE,
  input  logic [3:0]  MDOpE,
  input  logic [31:0] RData1E,
  input  logic [31:0] RData2E,
  input  logic [31:0] Imm32E,
  input  logic [4:0]  RtE,
  input  logic [4:0]  RdE,
  output logic        BusyE,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        MemWriteM,
  output logic [31:0] ALUOutM,
  output logic [31:0] WriteDataM,
  output logic [4:0]  WriteRegM
);
  logic [31:0] w_b, w_hi, w_lo, w_res;
  logic w_busy;
  mdu_core #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_mdu (
    .i_clk(Clk), .i_rst(Reset), .i_op(MDOpE), .i_a(RData1E), .i_b(RData2E),
    .o_hi(w_hi), .o_lo(w_lo), .o_busy(w_busy)
  );
  assign w_b = ALUSrcE ? Imm32E : RData2E;
  assign w_res = MDOpE == MD_MFHI ? w_hi : MDOpE == MD_MFLO ? w_lo : alu(ALUCtrlE, RData1E, w_b);
  assign BusyE = w_busy && is_md(MDOpE);
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset || BusyE) begin
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      MemWriteM <= 1'b0;
      ALUOutM <= '0;
      WriteDataM <= '0;
      WriteRegM <= '0;
    end else begin
      RegWriteM <= RegWriteE;
      MemtoRegM <= MemtoRegE;
      MemWriteM <= MemWriteE;
      ALUOutM <= w_res;
      WriteDataM <= RData2E;
      WriteRegM <= RegDstE ? RdE : RtE;
    end
  end
endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb_ex_stage_mdu: scoreboard bench for the EX stage with HI/LO tracking and stall-cycle counting.
module tb_ex_stage_mdu;
  logic Clk = 0, Reset = 0;
  logic RegWriteE = 0, MemtoRegE = 0, MemWriteE = 0, ALUSrcE = 0, RegDstE = 0;
  logic [2:0] ALUCtrlE = 0;
  logic [3:0] MDOpE = 0;
  logic [31:0] RData1E = 0, RData2E = 0, Imm32E = 0;
  logic [4:0] RtE = 0, RdE = 0;
  logic BusyE, RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0] WriteRegM;
  typedef struct packed {
    logic rw, mtr, mw;
    logic [31:0] out, wd;
    logic [4:0] wr;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, busy_seen = 0, m_cnt = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;

  ex_stage_mdu dut (
    .Clk(Clk), .Reset(Reset), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUCtrlE(ALUCtrlE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .MDOpE(MDOpE), .RData1E(RData1E),
    .RData2E(RData2E), .Imm32E(Imm32E), .RtE(RtE), .RdE(RdE), .BusyE(BusyE), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .WriteRegM(WriteRegM)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc(input string nm, input logic rw, input logic mtr, input logic mw, input logic [2:0] ctrl,
                     input logic srcb, input logic rdst, input logic [3:0] md, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rt, input logic [4:0] rd,
                     input logic [31:0] exp_alu, input logic [31:0] phi, input logic [31:0] plo);
    exp_t e, got;
    logic stall;
    logic [31:0] out;
    RegWriteE = rw; MemtoRegE = mtr; MemWriteE = mw; ALUCtrlE = ctrl; ALUSrcE = srcb; RegDstE = rdst;
    MDOpE = md; RData1E = a; RData2E = b; Imm32E = imm; RtE = rt; RdE = rd;
    stall = md != 0 && md <= 8 && m_cnt != 0;
    out = md == 5 ? m_hi : md == 6 ? m_lo : exp_alu;
    e = stall ? exp_t'(0) : exp_t'{rw, mtr, mw, out, b, rdst ? rd : rt};
    q.push_back(e);
    #1;
    checks++;
    if (BusyE !== stall) begin
      errors++;
      $display("FAIL %s busy: got %b want %b", nm, BusyE, stall);
    end
    if (BusyE === 1'b1) busy_seen++;
    @(posedge Clk);
    if (m_cnt == 1) begin
      m_hi = m_phi;
      m_lo = m_plo;
    end
    if (m_cnt != 0) m_cnt--;
    else if (md >= 1 && md <= 4) begin
      m_phi = phi;
      m_plo = plo;
      m_cnt = md <= 2 ? 5 : 10;
    end else if (md == 7) m_hi = a;
    else if (md == 8) m_lo = a;
    #1;
    got = '{RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM};
    e = q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s mem: got rw%b mr%b mw%b out=%h wd=%h wr=%0d want rw%b mr%b mw%b out=%h wd=%h wr=%0d",
               nm, got.rw, got.mtr, got.mw, got.out, got.wd, got.wr, e.rw, e.mtr, e.mw, e.out, e.wd, e.wr);
    end
  endtask

  task automatic alu_op(input string nm, input logic [2:0] ctrl, input logic srcb, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic [31:0] exp);
    cyc(nm, 1, 0, 0, ctrl, srcb, 1, 0, a, b, imm, 5'd9, 5'd3, exp, 0, 0);
  endtask

  task automatic md_op(input string nm, input logic [3:0] md, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] phi, input logic [31:0] plo);
    cyc(nm, md == 5 || md == 6, 0, 0, 3'd0, 0, 1, md, a, b, 0, 5'd9, 5'd4, a + b, phi, plo);
  endtask

  task automatic hold_until_done(input string nm, input logic [3:0] md, input int exp_busy, input logic [31:0] exp_val);
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      automatic bit was_busy = m_cnt != 0;
      md_op(nm, md, 0, 0, 0, 0);
      if (!was_busy) break;
    end
    checks++;
    if (busy_seen != exp_busy) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d want %0d", nm, busy_seen, exp_busy);
    end
    checks++;
    if (ALUOutM !== exp_val) begin
      errors++;
      $display("FAIL %s result: got %h want %h", nm, ALUOutM, exp_val);
    end
  endtask

  task automatic test_reset();
    #1 Reset = 1;
    #2;
    checks++;
    if ({BusyE, RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy%b out=%h wd=%h wr=%0d want all zero", BusyE, ALUOutM, WriteDataM, WriteRegM);
    end
    @(posedge Clk);
    #1 Reset = 0;
  endtask

  task automatic test_alu();
    alu_op("add", 3'd0, 0, 5, 7, 0, 12);
    alu_op("sub", 3'd1, 0, 5, 7, 0, 32'hFFFF_FFFE);
    alu_op("and", 3'd2, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 32'h00F0_00F0);
    alu_op("or", 3'd3, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 32'hFFF0_FFF0);
    alu_op("slt_true", 3'd4, 0, 32'hFFFF_FFFF, 1, 0, 1);
    alu_op("slt_false", 3'd4, 0, 1, 32'hFFFF_FFFF, 0, 0);
    alu_op("lui", 3'd5, 1, 0, 32'h5555_5555, 32'h1234, 32'h1234_0000);
    alu_op("xor", 3'd6, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 32'hFF00_FF00);
    alu_op("nor", 3'd7, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 32'h000F_000F);
    alu_op("add_imm_wrap", 3'd0, 1, 32'h100, 7, 32'hFFFF_FFFF, 32'hFF);
    cyc("store_rt", 0, 0, 1, 3'd0, 1, 0, 0, 32'h1000, 32'hCAFE, 4, 5'd9, 5'd3, 32'h1004, 0, 0);
    cyc("load_rt", 1, 1, 0, 3'd0, 1, 0, 0, 32'h2000, 32'h1, 8, 5'd17, 5'd3, 32'h2008, 0, 0);
  endtask

  task automatic test_hilo_moves();
    md_op("mthi", 4'd7, 32'hDEAD_BEEF, 0, 0, 0);
    md_op("mfhi", 4'd5, 0, 0, 0, 0);
    checks++;
    if (ALUOutM !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL mfhi_value: got %h want deadbeef", ALUOutM);
    end
    md_op("mtlo", 4'd8, 32'h1234_5678, 0, 0, 0);
    md_op("mflo", 4'd6, 0, 0, 0, 0);
  endtask

  task automatic test_mult();
    md_op("mult", 4'd1, 32'hFFFF_FFFD, 4, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    hold_until_done("mult_mflo", 4'd6, 5, 32'hFFFF_FFF4);
    md_op("mult_mfhi", 4'd5, 0, 0, 0, 0);
  endtask

  task automatic test_div();
    md_op("div", 4'd3, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    hold_until_done("div_mflo", 4'd6, 10, 32'hFFFF_FFFD);
    md_op("div_mfhi", 4'd5, 0, 0, 0, 0);
    md_op("divu0", 4'd4, 9, 0, 9, 32'hFFFF_FFFF);
    hold_until_done("divu0_mfhi", 4'd5, 10, 9);
    md_op("divu0_mflo", 4'd6, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    md_op("multu", 4'd2, 32'hFFFF_FFFF, 2, 1, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) alu_op("add_while_busy", 3'd0, 0, i, 10, 0, i + 10);
    hold_until_done("multu_mfhi", 4'd5, 1, 1);
    md_op("multu_mflo", 4'd6, 0, 0, 0, 0);
    md_op("mult_start", 4'd1, 7, 6, 0, 42);
    md_op("mult_retry", 4'd1, 3, 3, 0, 9);
    hold_until_done("mult_retry_mflo", 4'd6, 4, 42);
  endtask

  task automatic test_reset_mid();
    md_op("div_abort", 4'd3, 100, 7, 2, 14);
    md_op("nop1", 4'd0, 1, 1, 0, 0);
    md_op("nop2", 4'd0, 1, 1, 0, 0);
    MDOpE = 4'd6;
    #2 Reset = 1;
    #1;
    checks++;
    if ({BusyE, RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy%b out=%h wd=%h wr=%0d want all zero", BusyE, ALUOutM, WriteDataM, WriteRegM);
    end
    q.delete();
    m_cnt = 0; m_hi = 0; m_lo = 0;
    @(posedge Clk);
    #1 Reset = 0;
    md_op("post_reset_mfhi", 4'd5, 0, 0, 0, 0);
    md_op("post_reset_mflo", 4'd6, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_hilo_moves();
    test_mult();
    test_div();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
